sequenciador_bcd_ascii: RTL and testbench
=========================================

# sequenciador_bcd_ascii

Upstream controller for the BCD-to-ASCII serial transmitter. On a start request it latches an 8-bit binary measurement, saturates it to 99, converts it to two packed BCD digits with a sequential double-dabble, then drives the transmitter through two characters: tens first, units second. It owns the transmitter's `bcd`, `seletor_valor` and `inicio_transmissao_bcd` inputs and consumes its `pronto_transmissao_bcd`.

## Interface
Parameters:
- `ENVIA_ZERO_DEZENA`, default 1: 1 = always send the tens digit; 0 = skip the tens character when the tens digit is 0.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low; `reset`=0 forces the reset state immediately.
- `iniciar`  in  1  start request; sampled only in `INICIAL`.
- `valor`  in  8  unsigned binary measurement; sampled on the accepted `iniciar` edge.
- `pronto_transmissao_bcd`  in  1  one-cycle pulse from the transmitter at the end of a character.
- `bcd`  out  8  packed BCD: [7:4] tens, [3:0] units.
- `seletor_valor`  out  1  1 = tens nibble, 0 = units nibble.
- `inicio_transmissao_bcd`  out  1  one-cycle start pulse to the transmitter.
- `ocupado`  out  1  high from the cycle after acceptance until `FINAL` completes.
- `pronto`  out  1  one-cycle pulse: both characters done.
- `db_estado`  out  4  current state encoding, for the display.

## Operation
- States: `INICIAL`, `CONVERTE`, `ENVIA_DEZENA`, `ESPERA_DEZENA`, `ENVIA_UNIDADE`, `ESPERA_UNIDADE`, `FINAL`.
- `INICIAL` with `iniciar`=1 latches min(`valor`, 99) and goes to `CONVERTE`. With `iniciar`=0 it stays in `INICIAL`.
- `CONVERTE` runs for exactly 8 cycles. Each cycle does one double-dabble iteration: add 3 to any BCD nibble ≥5, then shift left one bit.
- Leaving `CONVERTE`:
  - Goes to `ENVIA_DEZENA`.
  - When `ENVIA_ZERO_DEZENA`=0 and the tens digit is 0, goes straight to `ENVIA_UNIDADE` instead.
- `ENVIA_DEZENA`: `seletor_valor`=1 and `inicio_transmissao_bcd`=1 for one cycle, then `ESPERA_DEZENA`.
- `ESPERA_DEZENA`: holds `seletor_valor`=1 until `pronto_transmissao_bcd`=1, then `ENVIA_UNIDADE`.
- `ENVIA_UNIDADE`: `seletor_valor`=0 and `inicio_transmissao_bcd`=1 for one cycle, then `ESPERA_UNIDADE`.
- `ESPERA_UNIDADE`: waits for `pronto_transmissao_bcd`=1, then `FINAL`.
- `FINAL`: `pronto`=1 for one cycle, then `INICIAL`.
- `bcd` is updated only at the end of `CONVERTE`. It holds that value until the next conversion ends, including through `INICIAL`.
- Arithmetic:
  - Shift register is 16 bits: 8 BCD bits followed by 8 binary bits.
  - The hundreds nibble is not needed because the input is saturated to ≤99.
  - Iteration counter is 3 bits and wraps from 7 to 0 on exit.

## Timing
- Reset values: `bcd`=8'h00, `seletor_valor`=0, `inicio_transmissao_bcd`=0, `ocupado`=0, `pronto`=0, `db_estado`=`INICIAL`.
- Latency when the transmitter answers immediately:
  - `iniciar` accepted at edge 0.
  - `CONVERTE` occupies cycles 1–8.
  - The first `inicio_transmissao_bcd` pulse is in cycle 9.
- The second `inicio_transmissao_bcd` pulse comes 2 cycles after the tens `pronto_transmissao_bcd` pulse.
- `pronto` comes 2 cycles after the units `pronto_transmissao_bcd` pulse.
- `iniciar` is ignored in every state except `INICIAL`. It is not queued.
- `pronto_transmissao_bcd` is ignored outside the two `ESPERA_*` states. A pulse in the same cycle as an `ENVIA_*` state is ignored.
- Holding `iniciar` high:
  - Starts a new sequence on the cycle after `FINAL`.
  - Back-to-back sequences therefore have one `INICIAL` cycle between them.
- Reset asserted mid-sequence:
  - Immediately returns to `INICIAL` with all outputs at reset values.
  - No `pronto` is produced.
  - A character already in flight downstream is not tracked; its `pronto_transmissao_bcd` is ignored in `INICIAL`.

## Structure
- Shared package holds:
  - The state enumeration with a 4-bit encoding (`INICIAL`=0 … `FINAL`=6), which `db_estado` exports.
  - The constant `VALOR_MAXIMO`=99.
  - The constant `N_ITERACOES`=8.
- Natural sub-module `conversor_bin_bcd`: sequential double-dabble.
  - Signals: `clock`, `reset`, `converte`, `bin`[7:0], `bcd`[7:0], `fim`.
  - The control FSM stays in the parent.

## Test plan
- `valor`=8'd57, transmitter pronto 5 cycles after each start -> `bcd`=8'h57; start pulses with `seletor_valor`=1 then 0; `pronto` once; first start in cycle 9.
- `valor`=8'd200 -> saturated, `bcd`=8'h99.
- `valor`=8'd0 -> `bcd`=8'h00.
- `valor`=8'd7, `ENVIA_ZERO_DEZENA`=0 -> `bcd`=8'h07; a single start pulse with `seletor_valor`=0, then `pronto`.
- Same `valor`=8'd7 with `ENVIA_ZERO_DEZENA`=1 -> two start pulses.
- `iniciar` pulsed during `ESPERA_DEZENA`, plus a spurious `pronto_transmissao_bcd` in `INICIAL` -> no extra sequence, no state change, exactly one `pronto`.
- `reset`=0 asserted in `ESPERA_UNIDADE` -> all outputs 0 immediately, `db_estado`=0, no `pronto`; a fresh `valor`=8'd42 afterwards completes normally with `bcd`=8'h42.

Source files
------------

// File: rtl/sequenciador_bcd_ascii_pkg.sv
// Shared definitions for the BCD-to-ASCII transmit sequencer: state encoding,
// saturation limit and the double-dabble step used by the converter.
package sequenciador_bcd_ascii_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    CONVERTE       = 4'd1,
    ENVIA_DEZENA   = 4'd2,
    ESPERA_DEZENA  = 4'd3,
    ENVIA_UNIDADE  = 4'd4,
    ESPERA_UNIDADE = 4'd5,
    FINAL          = 4'd6
  } estado_t;

  localparam logic [7:0] VALOR_MAXIMO = 8'd99;
  localparam int         N_ITERACOES  = 8;

  function automatic logic [7:0] satura(input logic [7:0] v);
    return (v > VALOR_MAXIMO) ? VALOR_MAXIMO : v;
  endfunction

  // One double-dabble iteration on {tens, units, binary}: adjust, then shift.
  function automatic logic [15:0] passo_dabble(input logic [15:0] r);
    logic [15:0] t;
    t = r;
    if (t[11:8] >= 4'd5)  t[11:8]  = t[11:8] + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    return {t[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/sequenciador_bcd_ascii_conversor.sv
// Sequential 8-bit binary to two-digit packed BCD converter (double-dabble),
// one iteration per clock; bcd is published only when the last iteration ends.
module conversor_bin_bcd
  import sequenciador_bcd_ascii_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       converte,
  input  logic [7:0] bin,
  output logic [7:0] bcd,
  output logic       fim
);

  logic [15:0] registro;
  logic [15:0] proximo;
  logic [2:0]  contador;
  logic        ativo;

  assign proximo = passo_dabble(registro);
  assign fim     = ativo && (contador == 3'(N_ITERACOES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ativo    <= 1'b0;
      contador <= 3'd0;
      bcd      <= 8'h00;
    end else if (converte) begin
      ativo    <= 1'b1;
      contador <= 3'd0;
    end else if (ativo) begin
      contador <= contador + 3'd1;
      if (fim) begin
        ativo <= 1'b0;
        bcd   <= proximo[15:8];
      end
    end
  end

  // Datapath shift register carries no reset; it is always loaded before use.
  always_ff @(posedge clock) begin
    if (converte)   registro <= {8'h00, bin};
    else if (ativo) registro <= proximo;
  end

endmodule

// File: rtl/sequenciador_bcd_ascii.sv
// Upstream controller: latches and saturates a measurement, converts it to BCD
// and drives the serial transmitter through the tens and units characters.
module sequenciador_bcd_ascii
  import sequenciador_bcd_ascii_pkg::*;
#(
  parameter bit ENVIA_ZERO_DEZENA = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [7:0] valor,
  input  logic       pronto_transmissao_bcd,
  output logic [7:0] bcd,
  output logic       seletor_valor,
  output logic       inicio_transmissao_bcd,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  estado_t estado;
  logic    aceita;
  logic    fim;
  logic    dezena_zero;
  logic    pronto_tx_r;

  assign aceita    = (estado == INICIAL) && iniciar;
  assign db_estado = estado;

  conversor_bin_bcd u_conversor (
    .clock    (clock),
    .reset    (reset),
    .converte (aceita),
    .bin      (satura(valor)),
    .bcd      (bcd),
    .fim      (fim)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado                 <= INICIAL;
      seletor_valor          <= 1'b0;
      inicio_transmissao_bcd <= 1'b0;
      ocupado                <= 1'b0;
      pronto                 <= 1'b0;
      dezena_zero            <= 1'b0;
      pronto_tx_r            <= 1'b0;
    end else begin
      inicio_transmissao_bcd <= 1'b0;
      pronto                 <= 1'b0;
      // Transmitter handshake is retimed, and only accepted while waiting.
      pronto_tx_r <= pronto_transmissao_bcd &&
                     (estado == ESPERA_DEZENA || estado == ESPERA_UNIDADE);
      case (estado)
        INICIAL: if (iniciar) begin
          estado      <= CONVERTE;
          ocupado     <= 1'b1;
          dezena_zero <= (satura(valor) < 8'd10);
        end
        CONVERTE: if (fim) begin
          inicio_transmissao_bcd <= 1'b1;
          if (!ENVIA_ZERO_DEZENA && dezena_zero) begin
            estado        <= ENVIA_UNIDADE;
            seletor_valor <= 1'b0;
          end else begin
            estado        <= ENVIA_DEZENA;
            seletor_valor <= 1'b1;
          end
        end
        ENVIA_DEZENA: estado <= ESPERA_DEZENA;
        ESPERA_DEZENA: if (pronto_tx_r) begin
          estado                 <= ENVIA_UNIDADE;
          seletor_valor          <= 1'b0;
          inicio_transmissao_bcd <= 1'b1;
        end
        ENVIA_UNIDADE: estado <= ESPERA_UNIDADE;
        ESPERA_UNIDADE: if (pronto_tx_r) begin
          estado <= FINAL;
          pronto <= 1'b1;
        end
        FINAL: begin
          estado  <= INICIAL;
          ocupado <= 1'b0;
        end
        default: estado <= INICIAL;
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_bcd_ascii.sv
// Directed bench for the BCD transmit sequencer: vector table of complete
// sequences on both tens-policy variants plus multi-cycle corner cases.
module tb_sequenciador_bcd_ascii;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar_v = 1'b0;
  logic [7:0] valor = 8'd0;
  logic       sel_dut = 1'b1;
  logic       tx_pulse = 1'b0;
  logic       tx_force = 1'b0;
  int         cyc = 0;

  logic       iniciar0, iniciar1, ptx0, ptx1;
  logic [7:0] bcd0, bcd1;
  logic       sel0, sel1, ini0, ini1, ocu0, ocu1, pr0, pr1;
  logic [3:0] est0, est1;

  logic [7:0] m_bcd;
  logic       m_sel, m_inicio, m_ocupado, m_pronto;
  logic [3:0] m_estado;

  assign iniciar0 = !sel_dut && iniciar_v;
  assign iniciar1 =  sel_dut && iniciar_v;
  assign ptx0     = !sel_dut && (tx_pulse || tx_force);
  assign ptx1     =  sel_dut && (tx_pulse || tx_force);

  assign m_bcd     = sel_dut ? bcd1 : bcd0;
  assign m_sel     = sel_dut ? sel1 : sel0;
  assign m_inicio  = sel_dut ? ini1 : ini0;
  assign m_ocupado = sel_dut ? ocu1 : ocu0;
  assign m_pronto  = sel_dut ? pr1  : pr0;
  assign m_estado  = sel_dut ? est1 : est0;

  sequenciador_bcd_ascii #(.ENVIA_ZERO_DEZENA(1'b0)) dut0 (
    .clock(clock), .reset(reset), .iniciar(iniciar0), .valor(valor),
    .pronto_transmissao_bcd(ptx0), .bcd(bcd0), .seletor_valor(sel0),
    .inicio_transmissao_bcd(ini0), .ocupado(ocu0), .pronto(pr0), .db_estado(est0)
  );

  sequenciador_bcd_ascii #(.ENVIA_ZERO_DEZENA(1'b1)) dut1 (
    .clock(clock), .reset(reset), .iniciar(iniciar1), .valor(valor),
    .pronto_transmissao_bcd(ptx1), .bcd(bcd1), .seletor_valor(sel1),
    .inicio_transmissao_bcd(ini1), .ocupado(ocu1), .pronto(pr1), .db_estado(est1)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Event log filled on the falling edge, where outputs are stable.
  int n_starts = 0, n_pr = 0, n_tx = 0, pr_cyc = 0;
  int start_cyc[4], start_sel[4], start_bcd[4], tx_cyc[4];

  initial forever begin
    @(negedge clock);
    if (m_inicio) begin
      if (n_starts < 4) begin
        start_cyc[n_starts] = cyc;
        start_sel[n_starts] = int'(m_sel);
        start_bcd[n_starts] = int'(m_bcd);
      end
      n_starts++;
    end
    if (m_pronto) begin
      pr_cyc = cyc;
      n_pr++;
    end
  end

  // Transmitter model: answers each start with a one-cycle pulse 5 cycles later.
  initial begin
    int cont;
    cont = 0;
    forever begin
      @(negedge clock);
      tx_pulse = 1'b0;
      if (cont > 0) begin
        cont--;
        if (cont == 0) begin
          tx_pulse = 1'b1;
          if (n_tx < 4) tx_cyc[n_tx] = cyc;
          n_tx++;
        end
      end
      if (m_inicio) cont = 5;
    end
  end

  task automatic clear_log();
    n_starts = 0; n_pr = 0; n_tx = 0;
  endtask

  task automatic wait_pronto(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clock); #1;
      if (n_pr > 0) done = 1'b1;
    end
    check(name, int'(done), 1);
  endtask

  task automatic wait_estado(input string name, input logic [3:0] alvo);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clock); #1;
      if (m_estado == alvo) done = 1'b1;
    end
    check(name, int'(done), 1);
  endtask

  task automatic run_seq(input logic [7:0] v, input logic [7:0] eb, input int ns, input logic d);
    int e;
    sel_dut = d;
    @(posedge clock); #1;
    clear_log();
    valor = v;
    iniciar_v = 1'b1;
    @(posedge clock); #1;
    e = cyc;
    iniciar_v = 1'b0;
    wait_pronto($sformatf("v%0d_d%0d_timeout", v, d));
    repeat (4) @(posedge clock);
    #1;
    check($sformatf("v%0d_d%0d_bcd", v, d), int'(m_bcd), int'(eb));
    check($sformatf("v%0d_d%0d_nstarts", v, d), n_starts, ns);
    check($sformatf("v%0d_d%0d_ntx", v, d), n_tx, ns);
    check($sformatf("v%0d_d%0d_first_start_cycle", v, d), start_cyc[0] - e, 8);
    check($sformatf("v%0d_d%0d_start_bcd", v, d), start_bcd[0], int'(eb));
    check($sformatf("v%0d_d%0d_sel_first", v, d), start_sel[0], (ns == 2) ? 1 : 0);
    if (ns == 2) begin
      check($sformatf("v%0d_d%0d_sel_second", v, d), start_sel[1], 0);
      check($sformatf("v%0d_d%0d_second_start_cycle", v, d), start_cyc[1], tx_cyc[0] + 2);
    end
    if (ns >= 1 && ns <= 4)
      check($sformatf("v%0d_d%0d_pronto_cycle", v, d), pr_cyc, tx_cyc[ns-1] + 2);
    check($sformatf("v%0d_d%0d_npronto", v, d), n_pr, 1);
    check($sformatf("v%0d_d%0d_ocupado_end", v, d), int'(m_ocupado), 0);
    check($sformatf("v%0d_d%0d_estado_end", v, d), int'(m_estado), 0);
  endtask

  typedef struct {
    logic [7:0] v;
    logic [7:0] eb;
    int         ns;
    logic       d;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'd57,  8'h57, 2, 1'b1};
    vecs[1] = '{8'd200, 8'h99, 2, 1'b1};
    vecs[2] = '{8'd0,   8'h00, 2, 1'b1};
    vecs[3] = '{8'd99,  8'h99, 2, 1'b1};
    vecs[4] = '{8'd100, 8'h99, 2, 1'b1};
    vecs[5] = '{8'd7,   8'h07, 1, 1'b0};
    vecs[6] = '{8'd7,   8'h07, 2, 1'b1};
    vecs[7] = '{8'd9,   8'h09, 1, 1'b0};
    vecs[8] = '{8'd10,  8'h10, 2, 1'b0};
    vecs[9] = '{8'd0,   8'h00, 1, 1'b0};

    #2;
    check("rst_bcd",     int'(bcd1) + int'(bcd0), 0);
    check("rst_sel",     int'(sel1) + int'(sel0), 0);
    check("rst_inicio",  int'(ini1) + int'(ini0), 0);
    check("rst_ocupado", int'(ocu1) + int'(ocu0), 0);
    check("rst_pronto",  int'(pr1)  + int'(pr0),  0);
    check("rst_estado",  int'(est1) + int'(est0), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    foreach (vecs[i]) run_seq(vecs[i].v, vecs[i].eb, vecs[i].ns, vecs[i].d);

    // Spurious transmitter pulse while idle, then iniciar during ESPERA_DEZENA.
    sel_dut = 1'b1;
    @(negedge clock) tx_force = 1'b1;
    @(negedge clock) tx_force = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("spurious_ptx_estado", int'(m_estado), 0);
    check("spurious_ptx_ocupado", int'(m_ocupado), 0);
    clear_log();
    valor = 8'd33;
    iniciar_v = 1'b1;
    @(posedge clock); #1;
    iniciar_v = 1'b0;
    wait_estado("reach_espera_dezena", 4'd3);
    iniciar_v = 1'b1;
    @(posedge clock); #1;
    iniciar_v = 1'b0;
    check("iniciar_ignored_estado", int'(m_estado), 3);
    wait_pronto("ignored_iniciar_timeout");
    repeat (20) @(posedge clock);
    #1;
    check("ignored_iniciar_npronto", n_pr, 1);
    check("ignored_iniciar_nstarts", n_starts, 2);
    check("ignored_iniciar_estado", int'(m_estado), 0);
    check("ignored_iniciar_bcd", int'(m_bcd), 8'h33);

    // Reset while waiting for the units character.
    clear_log();
    valor = 8'd88;
    iniciar_v = 1'b1;
    @(posedge clock); #1;
    iniciar_v = 1'b0;
    wait_estado("reach_espera_unidade", 4'd5);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_bcd",     int'(m_bcd), 0);
    check("midrst_sel",     int'(m_sel), 0);
    check("midrst_inicio",  int'(m_inicio), 0);
    check("midrst_ocupado", int'(m_ocupado), 0);
    check("midrst_pronto",  int'(m_pronto), 0);
    check("midrst_estado",  int'(m_estado), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check("midrst_no_pronto", n_pr, 0);
    check("midrst_inflight_ptx_ignored", int'(m_estado), 0);
    run_seq(8'd42, 8'h42, 2, 1'b1);

    // iniciar held high: one INICIAL cycle between back-to-back sequences.
    clear_log();
    valor = 8'd15;
    iniciar_v = 1'b1;
    wait_estado("hold_reach_final", 4'd6);
    check("hold_final_pronto", int'(m_pronto), 1);
    check("hold_final_ocupado", int'(m_ocupado), 1);
    @(posedge clock); #1;
    check("hold_gap_estado", int'(m_estado), 0);
    check("hold_gap_ocupado", int'(m_ocupado), 0);
    @(posedge clock); #1;
    check("hold_restart_estado", int'(m_estado), 1);
    iniciar_v = 1'b0;
    n_pr = 0;
    wait_pronto("hold_second_timeout");
    repeat (3) @(posedge clock);
    #1;
    check("hold_second_bcd", int'(m_bcd), 8'h15);
    check("hold_second_estado", int'(m_estado), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
